// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, grant FSM state, word type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

   localparam int WORD_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;
   localparam int STARVE_W   = 3;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

   typedef logic [WORD_W_DEF-1:0] word_t;

endpackage

// File: rtl/mem_arb_fsm.sv
// Grant FSM for the single-port RAM: picks data or instruction path, optional anti-starvation counter (MEM_ARB_FAIRNESS_EN).
// Latency: grant registered, one bubble from IDLE; completion cycles re-arbitrate with no bubble.
// Backpressure: holds a grant while the RAM reports FREE/BUSY; releases on withdrawal or ERROR.
module mem_arb_fsm
   import cpu_types_pkg::*;
`ifdef MEM_ARB_FAIRNESS_EN
   #(parameter int STARVE_MAX = 4)
`endif
(
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  logic      dREN,
   input  logic      dWEN,
   input  ramstate_t ramstate,
   output logic      i_act,
   output logic      d_act
);

   arb_state_t state, state_nxt, arb_pick;
   logic       d_req, i_done, d_done, pick_i;

   assign d_req  = dREN | dWEN;
   assign i_done = i_act & (ramstate == ACCESS);
   assign d_done = d_act & (ramstate == ACCESS);

`ifdef MEM_ARB_FAIRNESS_EN
   logic [STARVE_W-1:0] starve_cnt, starve_nxt;

   // Count data completions that happened while a fetch was waiting; any fetch completion or idle fetch clears it.
   always_comb begin
      starve_nxt = starve_cnt;
      if (i_done || ((i_done || d_done) && !iREN))
         starve_nxt = '0;
      else if (d_done && (starve_cnt != '1))
         starve_nxt = starve_cnt + 1'b1;
   end

   // Starvation counter register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) starve_cnt <= '0;
      else       starve_cnt <= starve_nxt;
   end

   // Post-update count is used so the fetch wins right after the limiting data completion.
   assign pick_i = iREN & (~d_req | (starve_nxt == STARVE_W'(STARVE_MAX)));
`else
   assign pick_i = iREN & ~d_req;
`endif

   assign arb_pick = pick_i ? IGRANT : (d_req ? DGRANT : IDLE);

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state: hold through FREE/BUSY, drop on withdrawal or ERROR, re-arbitrate on completion.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = arb_pick;
         IGRANT: begin
            if (!iREN || ramstate == ERROR) state_nxt = IDLE;
            else if (ramstate == ACCESS)    state_nxt = arb_pick;
         end
         DGRANT: begin
            if (!d_req || ramstate == ERROR) state_nxt = IDLE;
            else if (ramstate == ACCESS)     state_nxt = arb_pick;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: a grant is live only while its requester still holds the request.
   always_comb begin
      i_act = 1'b0;
      d_act = 1'b0;
      case (state)
         IGRANT:  i_act = iREN;
         DGRANT:  d_act = d_req;
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data paths; fairness option via MEM_ARB_FAIRNESS_EN.
// Latency: RAM driven one cycle after a request seen in IDLE; back-to-back grants with no bubble.
// Backpressure: iwait/dwait held high until the RAM reports ACCESS for the granted path.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
`ifdef MEM_ARB_FAIRNESS_EN
   , parameter int STARVE_MAX = 4
`endif
)
(
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   input  ramstate_t         ramstate,
   input  logic [WORD_W-1:0] ramload,
   output logic              iwait,
   output logic              dwait,
   output logic [WORD_W-1:0] iload,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   output logic              ramerr
);

   logic i_act, d_act;

   mem_arb_fsm
`ifdef MEM_ARB_FAIRNESS_EN
      #(.STARVE_MAX(STARVE_MAX))
`endif
   u_fsm (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .ramstate (ramstate),
      .i_act    (i_act),
      .d_act    (d_act)
   );

   // Route the live grant to the RAM and its completion back to the owner; a read+write is a write.
   always_comb begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      ramerr   = 1'b0;
      if (i_act) begin
         ramREN  = 1'b1;
         ramaddr = iaddr;
         ramerr  = (ramstate == ERROR);
         if (ramstate == ACCESS) begin
            iwait = 1'b0;
            iload = ramload;
         end
      end else if (d_act) begin
         ramaddr = daddr;
         ramWEN  = dWEN;
         ramREN  = dREN & ~dWEN;
         ramerr  = (ramstate == ERROR);
         if (dWEN) ramstore = dstore;
         if (ramstate == ACCESS) begin
            dwait = 1'b0;
            if (!dWEN) dload = ramload;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table through a scoreboard, plus a fairness run.
// Latency: vectors applied 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        nRST, iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   ramstate_t   ramstate;
   logic        iwait, dwait, ramREN, ramWEN, ramerr;
   logic [31:0] iload, dload, ramaddr, ramstore;

   always #5 CLK = ~CLK;

   mem_arbiter #(.WORD_W(32), .ADDR_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ramREN(ramREN),
      .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .ramerr(ramerr)
   );

   typedef struct {
      string       name;
      logic        rst, iren;
      logic [31:0] iaddr;
      logic        dren, dwen;
      logic [31:0] daddr, dstore;
      ramstate_t   rs;
      logic [31:0] rload;
      logic        eiw, edw, eren, ewen;
      logic [31:0] eil, edl, eaddr, estore;
      logic        eerr;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic v(input string nm, input logic rst, input logic iren, input logic [31:0] ia,
                    input logic dren, input logic dwen, input logic [31:0] da, input logic [31:0] ds,
                    input ramstate_t rs, input logic [31:0] rl,
                    input logic eiw, input logic edw, input logic eren, input logic ewen,
                    input logic [31:0] eil, input logic [31:0] edl, input logic [31:0] eaddr,
                    input logic [31:0] estore, input logic eerr);
      vec_t r;
      r.name = nm; r.rst = rst; r.iren = iren; r.iaddr = ia; r.dren = dren; r.dwen = dwen;
      r.daddr = da; r.dstore = ds; r.rs = rs; r.rload = rl;
      r.eiw = eiw; r.edw = edw; r.eren = eren; r.ewen = ewen; r.eil = eil; r.edl = edl;
      r.eaddr = eaddr; r.estore = estore; r.eerr = eerr;
      vecs.push_back(r);
   endtask

   // Vector whose expected outputs are the quiet state (both waits high, everything else 0).
   task automatic vi(input string nm, input logic rst, input logic iren, input logic [31:0] ia,
                     input logic dren, input logic dwen, input logic [31:0] da, input logic [31:0] ds,
                     input ramstate_t rs, input logic [31:0] rl);
      v(nm, rst, iren, ia, dren, dwen, da, ds, rs, rl, 1, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic apply(input vec_t r);
      nRST = r.rst; iREN = r.iren; iaddr = r.iaddr; dREN = r.dren; dWEN = r.dwen;
      daddr = r.daddr; dstore = r.dstore; ramstate = r.rs; ramload = r.rload;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      logic exp_q[$];
      logic kind, ek;
      int   n_i, cyc;

      nRST = 0; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
      ramstate = FREE; ramload = 0;

      // Reset state, including requests presented while reset is held
      vi("rst0",      0, 0, 0,     0, 0, 0,     0,     FREE,   0);
      vi("rst_req",   0, 1, 'h40,  1, 1, 'h10,  'h5,   ACCESS, 'h9);
      // Instruction fetch: bubble, two BUSY, ACCESS; then withdrawal and ACCESS-in-IDLE ignored
      vi("if_bubble", 1, 1, 'h40,  0, 0, 0,     0,     FREE,   0);
      v ("if_busy1",  1, 1, 'h40,  0, 0, 0,     0,     BUSY,   0,           1, 1, 1, 0, 0, 0, 'h40, 0, 0);
      v ("if_busy2",  1, 1, 'h40,  0, 0, 0,     0,     BUSY,   0,           1, 1, 1, 0, 0, 0, 'h40, 0, 0);
      v ("if_acc",    1, 1, 'h40,  0, 0, 0,     0,     ACCESS, 'h8C220004,  0, 1, 1, 0, 'h8C220004, 0, 'h40, 0, 0);
      vi("if_drop",   1, 0, 'h40,  0, 0, 0,     0,     ACCESS, 'h1234);
      vi("idle_acc",  1, 0, 0,     0, 0, 0,     0,     ACCESS, 'h5555);
      // Collision: data write wins, fetch waits; then back-to-back fetches with no bubble
      vi("col_bub",   1, 1, 'h44,  0, 1, 'h100, 'hDEADBEEF, FREE, 0);
      v ("col_wbusy", 1, 1, 'h44,  0, 1, 'h100, 'hDEADBEEF, BUSY,   'hAAAA, 1, 1, 0, 1, 0, 0, 'h100, 'hDEADBEEF, 0);
      v ("col_wacc",  1, 1, 'h44,  0, 1, 'h100, 'hDEADBEEF, ACCESS, 'hAAAA, 1, 0, 0, 1, 0, 0, 'h100, 'hDEADBEEF, 0);
      vi("col_wdrop", 1, 1, 'h44,  0, 0, 'h100, 0,     BUSY,   0);
      vi("col_ibub",  1, 1, 'h44,  0, 0, 0,     0,     FREE,   0);
      v ("col_iacc",  1, 1, 'h44,  0, 0, 0,     0,     ACCESS, 'h11,        0, 1, 1, 0, 'h11, 0, 'h44, 0, 0);
      v ("col_ib2b",  1, 1, 'h48,  0, 0, 0,     0,     ACCESS, 'h22,        0, 1, 1, 0, 'h22, 0, 'h48, 0, 0);
      vi("col_idrop", 1, 0, 0,     0, 0, 0,     0,     FREE,   0);
      // Data read withdrawn after two BUSY cycles
      vi("wd_bub",    1, 0, 0,     1, 0, 'h200, 0,     FREE,   0);
      v ("wd_busy1",  1, 0, 0,     1, 0, 'h200, 0,     BUSY,   0,           1, 1, 1, 0, 0, 0, 'h200, 0, 0);
      v ("wd_busy2",  1, 0, 0,     1, 0, 'h200, 0,     BUSY,   0,           1, 1, 1, 0, 0, 0, 'h200, 0, 0);
      vi("wd_drop",   1, 0, 0,     0, 0, 'h200, 0,     ACCESS, 'h77);
      vi("wd_idle",   1, 0, 0,     0, 0, 0,     0,     FREE,   0);
      // Data read completes, then read+write treated as a write
      vi("rd_bub",    1, 0, 0,     1, 0, 'h300, 'h77,  FREE,   0);
      v ("rd_acc",    1, 0, 0,     1, 0, 'h300, 'h77,  ACCESS, 'h99,        1, 0, 1, 0, 0, 'h99, 'h300, 0, 0);
      v ("rw_acc",    1, 0, 0,     1, 1, 'h300, 'h5A,  ACCESS, 'h99,        1, 0, 0, 1, 0, 0, 'h300, 'h5A, 0);
      vi("rw_drop",   1, 0, 0,     0, 0, 0,     0,     FREE,   0);
      vi("rw_idle",   1, 0, 0,     0, 0, 0,     0,     FREE,   0);
      // RAM error during a fetch: one-cycle ramerr, one IDLE cycle, re-grant
      vi("er_bub",    1, 1, 'h80,  0, 0, 0,     0,     FREE,   0);
      v ("er_err",    1, 1, 'h80,  0, 0, 0,     0,     ERROR,  0,           1, 1, 1, 0, 0, 0, 'h80, 0, 1);
      vi("er_idle",   1, 1, 'h80,  0, 0, 0,     0,     FREE,   0);
      v ("er_regrant",1, 1, 'h80,  0, 0, 0,     0,     ACCESS, 'h33,        0, 1, 1, 0, 'h33, 0, 'h80, 0, 0);
      vi("er_drop",   1, 0, 0,     0, 0, 0,     0,     FREE,   0);
      // Reset asserted mid data write, then a fetch after release
      vi("rg_bub",    1, 0, 0,     0, 1, 'h10,  'h1,   FREE,   0);
      v ("rg_busy",   1, 0, 0,     0, 1, 'h10,  'h1,   BUSY,   0,           1, 1, 0, 1, 0, 0, 'h10, 'h1, 0);
      vi("rg_rst",    0, 0, 0,     0, 1, 'h10,  'h1,   BUSY,   0);
      vi("rg_rel",    1, 1, 'h60,  0, 0, 0,     0,     BUSY,   0);
      v ("rg_if",     1, 1, 'h60,  0, 0, 0,     0,     BUSY,   0,           1, 1, 1, 0, 0, 0, 'h60, 0, 0);
      vi("rg_drop",   1, 0, 0,     0, 0, 0,     0,     FREE,   0);

      for (int k = 0; k < vecs.size(); k++) begin
         @(posedge CLK); #1;
         apply(vecs[k]);
         sb.push_back(vecs[k]);
         @(negedge CLK);
         e = sb.pop_front();
         chk({e.name, ".iwait"},    {31'd0, iwait},  {31'd0, e.eiw});
         chk({e.name, ".dwait"},    {31'd0, dwait},  {31'd0, e.edw});
         chk({e.name, ".ramREN"},   {31'd0, ramREN}, {31'd0, e.eren});
         chk({e.name, ".ramWEN"},   {31'd0, ramWEN}, {31'd0, e.ewen});
         chk({e.name, ".iload"},    iload,           e.eil);
         chk({e.name, ".dload"},    dload,           e.edl);
         chk({e.name, ".ramaddr"},  ramaddr,         e.eaddr);
         chk({e.name, ".ramstore"}, ramstore,        e.estore);
         chk({e.name, ".ramerr"},   {31'd0, ramerr}, {31'd0, e.eerr});
      end

      // Fairness: both paths request continuously with the RAM completing every cycle
      @(posedge CLK); #1;
      nRST = 0; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
      @(posedge CLK); #1;
      nRST = 1; iREN = 1; dREN = 1; iaddr = 'h400; daddr = 'h800; ramstate = ACCESS;
      for (int k = 0; k < 20; k++) begin
`ifdef MEM_ARB_FAIRNESS_EN
         exp_q.push_back((k % 5) == 4);
`else
         exp_q.push_back(1'b0);
`endif
      end
      n_i = 0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 60) begin
         @(posedge CLK); #1;
         ramload = $urandom;
         @(negedge CLK);
         cyc++;
         if (!iwait || !dwait) begin
            chk("fair.both", {31'd0, (!iwait && !dwait)}, 32'd0);
            kind = !iwait;
            ek = exp_q.pop_front();
            chk("fair.kind", {31'd0, kind}, {31'd0, ek});
            if (kind) chk("fair.iload", iload, ramload);
            else      chk("fair.dload", dload, ramload);
            n_i += kind ? 1 : 0;
         end
      end
      if (exp_q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL fair.timeout: %0d completions missing after %0d cycles", exp_q.size(), cyc);
      end
`ifdef MEM_ARB_FAIRNESS_EN
      chk("fair.icount", n_i, 32'd4);
`else
      chk("fair.icount", n_i, 32'd0);
`endif
      @(posedge CLK); #1;
      iREN = 0; dREN = 0; ramstate = FREE;
      @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
